// File: rtl/nand2fpga_pkg.sv
// Shared constants for the 4-way 16-bit write-side demux.
// Channel indices and the default word width used by every file.
package nand2fpga_pkg;

    localparam int WORD_W = 16;
    localparam int NUM_CH = 4;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

endpackage

// File: rtl/dmux4way16_buf_if.sv
// Producer/consumer bundle for dmux4way16_buf.
// Ports: in, sel, in_valid, in_ready (producer side);
//        a, b, c, d, out_valid, out_ready (four consumer channels).
interface dmux4way16_buf_if
    import nand2fpga_pkg::*;
#(
    parameter int WIDTH = WORD_W
);

    logic [WIDTH-1:0] in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    // The block itself.
    modport slave (
        input  in, sel, in_valid, out_ready,
        output in_ready, a, b, c, d, out_valid
    );

    // Producer plus the four consumers.
    modport master (
        output in, sel, in_valid, out_ready,
        input  in_ready, a, b, c, d, out_valid
    );

endinterface

// File: rtl/hold_reg16.sv
// One-entry valid/ready buffer for a single demux channel.
// Ports: clk, reset, load, data_in, ready_in, data_out, valid_out.
module hold_reg16
    import nand2fpga_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    // A load wins over a drain so a refill in the drain cycle
    // keeps the channel valid with no bubble. Data is not zeroed
    // on drain; consumers qualify it with valid_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (load) begin
            data_out  <= data_in;
            valid_out <= 1'b1;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux4way16_buf.sv
// Routes one input word to one of four buffered output channels.
// Ports: clk, reset, bus (slave: in/sel/in_valid/in_ready, a..d/out_valid/out_ready).
module dmux4way16_buf
    import nand2fpga_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    dmux4way16_buf_if.slave  bus
);

    logic [WIDTH-1:0] data [NUM_CH];
    logic [3:0]       valid;
    logic [3:0]       load;
    logic             accept;

    // Readiness looks only at the selected channel, so a full
    // channel elsewhere never stalls the producer.
    assign bus.in_ready = ~valid[bus.sel] | bus.out_ready[bus.sel];
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = accept & (bus.sel == 2'(i));

        hold_reg16 #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk       (clk),
            .reset     (reset),
            .load      (load[i]),
            .data_in   (bus.in),
            .ready_in  (bus.out_ready[i]),
            .data_out  (data[i]),
            .valid_out (valid[i])
        );
    end

    assign bus.a         = data[CH_A];
    assign bus.b         = data[CH_B];
    assign bus.c         = data[CH_C];
    assign bus.d         = data[CH_D];
    assign bus.out_valid = valid;

endmodule
